// File: rtl/memory_responder.sv
// memory_responder: single-port word memory that answers one request at a time
// with a fixed latency of WAIT_STATES cycles in WAIT plus one RESPOND cycle.
//
// Ports
//   clk                    sole clock, rising edge
//   reset                  asynchronous, active-low
//   request_valid/ready    request handshake (ready only in IDLE)
//   store                  1 = write, 0 = read
//   memory_access_address  byte address, bits [1:0] ignored
//   memory_write_data      lane-steered store data
//   memory_write_mask      byte enables, bit i -> data[8i+7:8i]
//   response_valid         one-cycle response strobe (RESPOND state)
//   memory_read_data       load data, held between responses
//   response_error         word index out of range, only in the response cycle
//   fsm_state_dbg          current FSM state encoding for observation
//
// Handshake: a request transfers on a rising edge where request_valid and
// request_ready are both 1; request_ready is 1 only in IDLE, so request_valid
// and the request fields are ignored in WAIT and RESPOND. A request held high
// across those states is taken on the first IDLE edge. Responses have no
// backpressure: response_valid is high for exactly one cycle.
module memory_responder #(
    parameter int WAIT_STATES = 1,
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        request_valid,
    output logic        request_ready,
    input  logic        store,
    input  logic [31:0] memory_access_address,
    input  logic [31:0] memory_write_data,
    input  logic [3:0]  memory_write_mask,
    output logic        response_valid,
    output logic [31:0] memory_read_data,
    output logic        response_error,
    output logic [1:0]  fsm_state_dbg
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_U   = DEPTH_WORDS;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        store_q, store_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic           accept;
    logic           enter_respond;
    logic           acc_store;
    logic [29:0]    acc_addr;
    logic [31:0]    acc_wdata;
    logic [3:0]     acc_mask;
    logic           acc_in_range;
    logic [IDX_W-1:0] acc_idx;
    logic           mem_we;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^memory_access_address[1:0];

    assign request_ready  = (state_q == ST_IDLE);
    assign accept         = request_valid && request_ready;
    assign response_valid = (state_q == ST_RESPOND);
    assign memory_read_data = rdata_q;
    assign response_error = err_q;
    assign fsm_state_dbg  = state_q;

    // With zero wait states the array is accessed on the acceptance edge itself,
    // before the captured copy exists, so the live request fields are used.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_store = store;
            acc_addr  = memory_access_address[31:2];
            acc_wdata = memory_write_data;
            acc_mask  = memory_write_mask;
        end else begin
            acc_store = store_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_mask  = mask_q;
        end
    end

    // Full 30-bit unsigned compare: high address bits must never alias into the array.
    assign acc_in_range = ({2'b00, acc_addr} < DEPTH_U);
    assign acc_idx      = acc_addr[IDX_W-1:0];

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        store_d       = store_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        mask_d        = mask_q;
        rdata_d       = rdata_q;
        err_d         = 1'b0;
        enter_respond = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    store_d = store;
                    addr_d  = memory_access_address[31:2];
                    wdata_d = memory_write_data;
                    mask_d  = memory_write_mask;
                    if (WAIT_STATES > 0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d       = ST_RESPOND;
                        enter_respond = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d       = ST_RESPOND;
                    enter_respond = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_respond) begin
            err_d   = !acc_in_range;
            rdata_d = (!acc_store && acc_in_range) ? mem[acc_idx] : 32'd0;
        end
    end

    // A write commits only on the edge entering RESPOND; a request discarded by
    // reset in WAIT never reaches that edge.
    assign mem_we = enter_respond && acc_store && acc_in_range;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_mask[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            store_q    <= 1'b0;
            addr_q     <= 30'd0;
            wdata_q    <= 32'd0;
            mask_q     <= 4'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            store_q    <= store_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mask_q     <= mask_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, meaning extra cycles between request acceptance and response; legal range 0..15.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, meaning number of 32-bit words in the storage array.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port request_valid  input  1  the core presents a request this cycle.
REQ-006 SHALL have port request_ready  output  1  the responder accepts a request this cycle.
REQ-007 SHALL have port store  input  1  1 = write request, 0 = read request.
REQ-008 SHALL have port memory_access_address  input  32  byte address; bits [1:0] are ignored.
REQ-009 SHALL have port memory_write_data  input  32  lane-steered store data.
REQ-010 SHALL have port memory_write_mask  input  4  byte enables; bit i enables data bits [8i+7:8i].
REQ-011 SHALL have port response_valid  output  1  response is present for one cycle.
REQ-012 SHALL have port memory_read_data  output  32  load data, valid while response_valid is 1.
REQ-013 SHALL have port response_error  output  1  the address was out of range, valid while response_valid is 1.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT and RESPOND.
REQ-015 SHALL drive request_ready = 1 only in IDLE.
REQ-016 SHALL accept a request (handshake) on a rising edge where request_valid and request_ready are both 1.
- On acceptance: capture store, address[31:2], write data and mask.
REQ-017 On acceptance, the FSM SHALL go to WAIT if WAIT_STATES > 0, otherwise directly to RESPOND.
REQ-018 In WAIT, a counter SHALL load WAIT_STATES-1 on entry and decrement each cycle.
- At count 0 the FSM goes to RESPOND on the next edge.
- Time spent in WAIT is exactly WAIT_STATES cycles.
REQ-019 On the edge entering RESPOND, the array access SHALL be performed using the captured fields.
- Store: write each enabled byte of word index address[31:2].
- Load: register that word onto memory_read_data.
REQ-020 SHALL hold response_valid = 1 for exactly one cycle (the RESPOND state) and then return to IDLE.
- There is no response backpressure.
REQ-021 Latency SHALL be fixed.
- Response cycle begins WAIT_STATES+1 edges after the acceptance edge.
- Minimum request spacing is WAIT_STATES+2 cycles.
REQ-022 For a store, memory_read_data SHALL be 0 during the response.
REQ-023 A store with memory_write_mask = 4'b0000 SHALL leave the array unchanged and respond normally with response_error = 0.
REQ-024 If address[31:2] >= DEPTH_WORDS:
- No array write occurs.
- memory_read_data = 0.
- response_error = 1 in the response cycle.
REQ-025 response_error SHALL be 0 in all cycles other than an out-of-range response.
REQ-026 memory_read_data SHALL hold its last value outside response cycles.
REQ-027 request_valid and the request fields SHALL be ignored in WAIT and RESPOND.
- A request held across these states is accepted once the FSM returns to IDLE.
REQ-028 A load following a store to the same word SHALL return the post-write data.
REQ-029 Address comparison SHALL be unsigned over the full 30-bit word index; bits [1:0] never affect the access.

Reset
REQ-030 While reset = 0, regardless of clk:
- FSM = IDLE, so request_ready = 1.
- response_valid = 0, response_error = 0, memory_read_data = 0.
- WAIT counter = 0.
REQ-031 Reset asserted mid-operation (WAIT or RESPOND) SHALL discard the pending request; an uncommitted store is never written.
REQ-032 The storage array SHALL NOT be cleared by reset.
REQ-033 The first acceptance after reset deassertion SHALL occur on the first rising edge with request_valid = 1.

Verification
REQ-034 Basic write/read, WAIT_STATES=1:
- Stimulus: store addr 0x10, data 0xDEADBEEF, mask 4'b1111; then load addr 0x10.
- Response: response_valid 2 edges after each acceptance; load returns 0xDEADBEEF; response_error = 0.
REQ-035 Byte masks:
- Stimulus: store 0x11223344 mask 4'b1111 to addr 0x20; then store 0xAABBCCDD mask 4'b0101; then load 0x23.
- Response: load returns 0x11BB33DD.
REQ-036 Out of range, DEPTH_WORDS=256:
- Stimulus: store to 0x400; then load 0x400; then load 0x000.
- Response: the load of 0x400 gives response_error = 1 and data 0; the load of 0x000 shows the array unchanged.
REQ-037 Latency and ignore rule, WAIT_STATES=0 and WAIT_STATES=3:
- Stimulus: request_valid held high continuously.
- Response: acceptances every 2 and 5 cycles respectively; request_ready = 0 between acceptances.
REQ-038 Reset mid-operation, WAIT_STATES=3:
- Stimulus: store 0xCAFEF00D to 0x8; assert reset during WAIT; release reset; load 0x8.
- Response: outputs go to reset values immediately; load returns the prior contents, not 0xCAFEF00D.
REQ-039 Zero mask:
- Stimulus: store mask 4'b0000 to a word holding 0x12345678.
- Response: response_valid with response_error = 0; a subsequent load returns 0x12345678.
